// File: rtl/sar_search_if.sv
// Bus between the successive-approximation controller and its magnitude
// comparator: trial operand out, three relational flags back, plus the
// start/busy/done handshake and the held search outcome.
interface sar_search_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             Gt;
    logic             Eq;
    logic             Lt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    // Controller side: issues guesses, consumes comparator flags.
    modport master (
        input  start, Gt, Eq, Lt,
        output guess, busy, done, result, found, err
    );

    // Environment side: requests searches, supplies comparator flags.
    modport slave (
        output start, Gt, Eq, Lt,
        input  guess, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller. Finds the comparator's unknown
// b operand by binary search, MSB first, one trial per cycle, leaving early
// on Eq. A final VERIFY cycle confirms the assembled value. Malformed flag
// patterns (none or several set) end the search with err raised.
module sar_search #(
    parameter int WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    sar_search_if.master bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_guess,  w_guess_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [IDX_W-1:0] r_idx,    w_idx_nxt;
    logic             r_found,  w_found_nxt;
    logic             r_err,    w_err_nxt;
    logic             w_onehot;

    assign w_onehot = $onehot({bus.Gt, bus.Eq, bus.Lt});

    // Next-state and next-datapath decode; comparator flags are valid in the
    // same cycle as the guess because the comparator is purely combinational.
    always_comb begin
        // NOTE: every target takes its held value first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_idx_nxt    = r_idx;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_TRIAL;
                    w_guess_nxt = WIDTH'(1) << (WIDTH - 1);
                    w_idx_nxt   = IDX_W'(WIDTH - 1);
                    w_found_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end

            S_TRIAL: begin
                if (!w_onehot) begin
                    w_state_nxt  = S_DONE;
                    w_err_nxt    = 1'b1;
                    w_found_nxt  = 1'b0;
                    w_result_nxt = r_guess;
                end else if (bus.Eq) begin
                    w_state_nxt  = S_DONE;
                    w_found_nxt  = 1'b1;
                    w_result_nxt = r_guess;
                end else begin
                    // Lt keeps the trial bit, Gt clears it.
                    w_guess_nxt[r_idx] = bus.Lt;
                    if (r_idx != '0) begin
                        w_guess_nxt[r_idx - 1'b1] = 1'b1;
                        w_idx_nxt                 = r_idx - 1'b1;
                    end else begin
                        w_state_nxt = S_VERIFY;
                    end
                end
            end

            S_VERIFY: begin
                w_state_nxt  = S_DONE;
                w_result_nxt = r_guess;
                if (!w_onehot) begin
                    w_err_nxt   = 1'b1;
                    w_found_nxt = 1'b0;
                end else begin
                    // Lt or Gt here means the comparator contradicted itself.
                    w_found_nxt = bus.Eq;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any search.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (rst) begin
            r_state  <= S_IDLE;
            r_guess  <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_idx    <= w_idx_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.guess  = r_guess;
    assign bus.busy   = (r_state == S_TRIAL) || (r_state == S_VERIFY);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.found  = r_found;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search at WIDTH=2 and WIDTH=4. Each DUT sits beside a
// behavioural magnitude comparator whose flags can be overridden to inject
// faults. Expected guess sequences come from an interval-bisection model.
module tb_sar_search;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    sar_search_if #(.WIDTH(2)) bus2 ();
    sar_search_if #(.WIDTH(4)) bus4 ();

    logic [1:0] target2;
    logic [3:0] target4;
    logic       f2_en, f4_en;
    logic [2:0] f2_val, f4_val;

    // Comparators: {Gt, Eq, Lt}, optionally overridden.
    assign {bus2.Gt, bus2.Eq, bus2.Lt} = f2_en ? f2_val :
        {bus2.guess > target2, bus2.guess == target2, bus2.guess < target2};
    assign {bus4.Gt, bus4.Eq, bus4.Lt} = f4_en ? f4_val :
        {bus4.guess > target4, bus4.guess == target4, bus4.guess < target4};

    sar_search #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sar_search #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] g_guess(input int w);
        return (w == 2) ? 16'(bus2.guess) : 16'(bus4.guess);
    endfunction

    function automatic logic [15:0] g_result(input int w);
        return (w == 2) ? 16'(bus2.result) : 16'(bus4.result);
    endfunction

    // {busy, done, found, err}
    function automatic logic [15:0] g_stat(input int w);
        return (w == 2) ? 16'({bus2.busy, bus2.done, bus2.found, bus2.err})
                        : 16'({bus4.busy, bus4.done, bus4.found, bus4.err});
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 2) bus2.start = v;
        else        bus4.start = v;
    endtask

    task automatic set_target(input int w, input int t);
        if (w == 2) target2 = 2'(t);
        else        target4 = 4'(t);
    endtask

    // One search against an honest comparator. Model: bisect [lo,hi) until
    // the midpoint equals the target; the midpoint list is the guess list and
    // its length is the number of edges from acceptance to done.
    task automatic run(input int w, input int t, input bit hold_start);
        int lo, hi, mid, n;
        int exp_q[$];
        lo = 0;
        hi = 1 << w;
        for (int s = 0; s < 20; s++) begin
            mid = lo + (hi - lo) / 2;
            exp_q.push_back(mid);
            if (mid == t) break;
            if (mid < t) lo = mid;
            else         hi = mid;
        end
        n = exp_q.size();

        @(negedge clk);
        set_target(w, t);
        set_start(w, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!hold_start || k == n - 1) set_start(w, 1'b0);
            check($sformatf("w%0d t%0h guess%0d", w, t, k + 1), g_guess(w), 16'(exp_q[k]));
            check($sformatf("w%0d t%0h busy/done step%0d", w, t, k + 1),
                  g_stat(w) >> 2, 16'b10);
        end
        @(negedge clk);
        check($sformatf("w%0d t%0h done status", w, t), g_stat(w), 16'b0110);
        check($sformatf("w%0d t%0h result", w, t), g_result(w), 16'(t));
        @(negedge clk);
        check($sformatf("w%0d t%0h after done", w, t), g_stat(w), 16'b0010);
        check($sformatf("w%0d t%0h result held", w, t), g_result(w), 16'(t));
    endtask

    initial begin
        rst        = 1'b1;
        bus2.start = 1'b0;
        bus4.start = 1'b0;
        target2    = '0;
        target4    = '0;
        f2_en      = 1'b0;
        f4_en      = 1'b0;
        f2_val     = '0;
        f4_val     = '0;

        repeat (2) @(negedge clk);
        for (int w = 2; w <= 4; w += 2) begin
            check($sformatf("reset w%0d guess", w),  g_guess(w),  16'h0);
            check($sformatf("reset w%0d result", w), g_result(w), 16'h0);
            check($sformatf("reset w%0d status", w), g_stat(w),   16'h0);
        end
        rst = 1'b0;

        // Directed cases from the search rules.
        run(2, 1, 1'b0);
        run(2, 0, 1'b0);
        run(4, 11, 1'b0);

        // Every WIDTH=2 target.
        for (int t = 0; t < 4; t++) run(2, t, 1'b0);

        // start held high while busy must not disturb the search.
        run(4, 5, 1'b1);

        // Randomized targets on both widths.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1, 0) == 1) run(4, int'($urandom_range(15, 0)), 1'b0);
            else                           run(2, int'($urandom_range(3, 0)), 1'b0);
        end

        // Fault: Gt and Eq both set on trial 1.
        @(negedge clk);
        set_target(2, 1);
        f2_en  = 1'b1;
        f2_val = 3'b110;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        check("fault1 guess", g_guess(2), 16'h2);
        @(negedge clk);
        check("fault1 done status", g_stat(2), 16'b0101);
        check("fault1 result", g_result(2), 16'h2);
        f2_en = 1'b0;
        @(negedge clk);
        check("fault1 err held", g_stat(2), 16'b0001);

        // Fault: no flag set during VERIFY.
        set_target(2, 0);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        @(negedge clk);
        check("fault2 guess2", g_guess(2), 16'h1);
        @(negedge clk);
        check("fault2 verify guess", g_guess(2), 16'h0);
        f2_en  = 1'b1;
        f2_val = 3'b000;
        @(negedge clk);
        check("fault2 done status", g_stat(2), 16'b0101);
        check("fault2 result", g_result(2), 16'h0);
        f2_en = 1'b0;

        // A clean search afterwards clears err.
        run(2, 3, 1'b0);

        // Reset in the middle of a WIDTH=4 search.
        run(4, 9, 1'b0);
        @(negedge clk);
        set_target(4, 11);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        check("midrst guess before", g_guess(4), 16'hC);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst guess",  g_guess(4),  16'h0);
        check("midrst result", g_result(4), 16'h0);
        check("midrst status", g_stat(4),   16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("midrst idle%0d status", i), g_stat(4), 16'h0);
        end
        run(4, 7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
